ascii_scroll_mux_display: RTL and testbench

- Multi-digit successor to the single-digit ASCII 7-segment driver: holds an ASCII message buffer and time-multiplexes it onto N_DIGITS common-anode digits.
- Adds an optional right-to-left scroll for messages longer than the display, and anti-ghosting blanking at each digit switch.
- Sits between application logic, which writes characters, and the board's segment and digit-select pins.

---
 rtl/ascii_scroll_mux_display.sv | 241 ++++++++++++++++++++++++
 tb/tb_ascii_scroll_mux_display.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_scroll_mux_display.sv
// ascii_scroll_mux_display: N-digit multiplexed ASCII 7-segment driver with a
// message buffer, optional right-to-left scroll and blanking at digit switches.
//
// Ports:
//   clk50MHz    system clock
//   rst_n       synchronous active-low reset
//   wr_en       buffer write strobe
//   wr_addr     buffer entry index (values >= MSG_DEPTH are ignored)
//   wr_char     ASCII code for the entry
//   wr_dp       decimal point for the entry
//   msg_len     valid message length (clamped to MSG_DEPTH)
//   scroll_en   enable scrolling for messages longer than the display
//   Segments    {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
//   SEL         one-hot digit select, SEL[0] leftmost, polarity SEL_ACTIVE_LOW
//   frame_tick  one-cycle pulse after the last cycle of the last digit slot

module ascii_scroll_mux_display #(
    parameter int N_DIGITS      = 4,
    parameter int MSG_DEPTH     = 16,
    parameter int SLOT_CYCLES   = 12500,
    parameter int BLANK_CYCLES  = 50,
    parameter int SCROLL_FRAMES = 250,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                           clk50MHz,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0]   wr_addr,
    input  logic [7:0]                     wr_char,
    input  logic                           wr_dp,
    input  logic [$clog2(MSG_DEPTH+1)-1:0] msg_len,
    input  logic                           scroll_en,
    output logic [6:0]                     Segments,
    output logic                           dp,
    output logic [N_DIGITS-1:0]            SEL,
    output logic                           frame_tick
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = $clog2(MSG_DEPTH + 1);
    localparam int DW = $clog2(N_DIGITS);
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_C    = CW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(N_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(SCROLL_FRAMES - 1);
    localparam logic [LW-1:0] DEPTH_L    = LW'(MSG_DEPTH);
    localparam logic [LW-1:0] DIGITS_L   = LW'(N_DIGITS);

    localparam logic [N_DIGITS-1:0] SEL_OFF =
        SEL_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    if (N_DIGITS < 2 || N_DIGITS > 8) begin : g_bad_digits
        $error("N_DIGITS must be in 2..8");
    end
    if (MSG_DEPTH < N_DIGITS) begin : g_bad_depth
        $error("MSG_DEPTH must be >= N_DIGITS");
    end
    if (BLANK_CYCLES >= SLOT_CYCLES) begin : g_bad_blank
        $error("BLANK_CYCLES must be < SLOT_CYCLES");
    end

    // Active-low font; lower-case letters fold onto upper case first.
    function automatic logic [6:0] font(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (c >= 8'h61 && c <= 8'h7A) begin
            u = c - 8'h20;
        end
        case (u)
            8'h30:   font = 7'h40;
            8'h31:   font = 7'h79;
            8'h32:   font = 7'h24;
            8'h33:   font = 7'h30;
            8'h34:   font = 7'h19;
            8'h35:   font = 7'h12;
            8'h36:   font = 7'h02;
            8'h37:   font = 7'h78;
            8'h38:   font = 7'h00;
            8'h39:   font = 7'h10;
            8'h41:   font = 7'h08;
            8'h42:   font = 7'h03;
            8'h43:   font = 7'h46;
            8'h44:   font = 7'h21;
            8'h45:   font = 7'h06;
            8'h46:   font = 7'h0E;
            8'h2D:   font = 7'h3F;
            8'h5F:   font = 7'h77;
            8'h20:   font = 7'h7F;
            default: font = 7'h7F;
        endcase
    endfunction

    // Message buffer
    logic [7:0] buf_char [MSG_DEPTH];
    logic       buf_dp   [MSG_DEPTH];
    logic       wr_ok;

    assign wr_ok = wr_en && (LW'(wr_addr) < DEPTH_L);

    always_ff @(posedge clk50MHz) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                buf_char[i] <= 8'h20;
                buf_dp[i]   <= 1'b0;
            end
        end else if (wr_ok) begin
            buf_char[wr_addr] <= wr_char;
            buf_dp[wr_addr]   <= wr_dp;
        end
    end

    // Scan counters
    logic [CW-1:0] slot_cnt;
    logic [DW-1:0] digit_idx;
    logic          slot_wrap;
    logic          frame_end;

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_wrap && (digit_idx == DIGIT_LAST);

    always_ff @(posedge clk50MHz) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_wrap) begin
            slot_cnt  <= '0;
            digit_idx <= frame_end ? '0 : digit_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Effective length and scroll mode
    logic [LW-1:0] eff_len;
    logic          scroll_mode;

    assign eff_len     = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
    assign scroll_mode = scroll_en && (eff_len > DIGITS_L);

    // Scroll position: steps once every SCROLL_FRAMES frames.
    logic [AW-1:0] start;
    logic [LW-1:0] start_l;
    logic [FW-1:0] frame_cnt;

    assign start_l = LW'(start);

    always_ff @(posedge clk50MHz) begin
        if (!rst_n) begin
            start     <= '0;
            frame_cnt <= '0;
        end else if (!scroll_mode) begin
            start     <= '0;
            frame_cnt <= '0;
        end else if (start_l >= eff_len) begin
            // msg_len shrank under the current position
            start <= '0;
        end else if (frame_end) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                if ((start_l + LW'(1)) == eff_len) begin
                    start <= '0;
                end else begin
                    start <= start + 1'b1;
                end
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Buffer index for the digit being scanned. An index at or past the
    // effective length blanks the digit, which also covers L=0.
    logic [LW:0]   rd_idx;
    logic          rd_valid;
    logic [AW-1:0] rd_addr;

    always_comb begin
        rd_idx = (LW+1)'(digit_idx);
        unique case (1'b1)
            scroll_mode: begin
                rd_idx = {1'b0, start_l} + (LW+1)'(digit_idx);
                if (rd_idx >= {1'b0, eff_len}) begin
                    rd_idx = rd_idx - {1'b0, eff_len};
                end
            end
            !scroll_mode: begin
                rd_idx = (LW+1)'(digit_idx);
            end
        endcase
        rd_valid = (rd_idx < {1'b0, eff_len});
        rd_addr  = rd_valid ? rd_idx[AW-1:0] : '0;
    end

    // Next output values
    logic                in_blank;
    logic [6:0]          seg_d;
    logic                dp_d;
    logic [N_DIGITS-1:0] onehot;

    assign in_blank = (slot_cnt < BLANK_C);
    assign onehot   = N_DIGITS'(1) << digit_idx;

    always_comb begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!in_blank && rd_valid) begin
            seg_d = font(buf_char[rd_addr]);
            dp_d  = ~buf_dp[rd_addr];
        end
    end

    // Registered outputs
    logic [6:0]          seg_q;
    logic                dp_q;
    logic [N_DIGITS-1:0] sel_q;
    logic                tick_q;

    always_ff @(posedge clk50MHz) begin
        if (!rst_n) begin
            seg_q  <= 7'h7F;
            dp_q   <= 1'b1;
            sel_q  <= SEL_OFF;
            tick_q <= 1'b0;
        end else begin
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            sel_q  <= SEL_ACTIVE_LOW ? ~onehot : onehot;
            tick_q <= frame_end;
        end
    end

    assign Segments   = seg_q;
    assign dp         = dp_q;
    assign SEL        = sel_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_ascii_scroll_mux_display.sv
// tb_ascii_scroll_mux_display: scenario tasks plus randomized traffic,
// checked against a cycle-count based reference model.

module tb_ascii_scroll_mux_display;

    localparam int ND    = 4;
    localparam int DEPTH = 12;
    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int SF    = 2;
    localparam int FRAME = SLOT * ND;

    logic       clk50MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_char = '0;
    logic       wr_dp = 1'b0;
    logic [3:0] msg_len = '0;
    logic       scroll_en = 1'b0;
    logic [6:0] Segments;
    logic       dp;
    logic [3:0] SEL;
    logic       frame_tick;

    ascii_scroll_mux_display #(
        .N_DIGITS(ND), .MSG_DEPTH(DEPTH), .SLOT_CYCLES(SLOT),
        .BLANK_CYCLES(BLANK), .SCROLL_FRAMES(SF), .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .clk50MHz(clk50MHz), .rst_n(rst_n), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_char(wr_char), .wr_dp(wr_dp),
        .msg_len(msg_len), .scroll_en(scroll_en),
        .Segments(Segments), .dp(dp), .SEL(SEL),
        .frame_tick(frame_tick)
    );

    always #5 clk50MHz = ~clk50MHz;

    localparam logic [7:0] FONT_KEYS [19] = '{
        8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
        8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46,
        8'h2D, 8'h5F, 8'h20};
    localparam logic [6:0] FONT_PATS [19] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
        7'h3F, 7'h77, 7'h7F};

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] m_char [DEPTH];
    logic       m_dp   [DEPTH];
    int         n;
    int         m_start;
    int         m_fcnt;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_sel;
    logic       e_ft;

    function automatic logic [6:0] ref_font(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'd32 : c;
        ref_font = 7'h7F;
        for (int i = 0; i < 19; i++) begin
            if (FONT_KEYS[i] == u) ref_font = FONT_PATS[i];
        end
    endfunction

    // One clock: the model works from the cycle count n since reset
    // release; outputs seen after an edge describe the state before it.
    task automatic tick();
        int  digit, c, len, idx;
        bit  scr, fend;
        @(posedge clk50MHz);
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_char[i] = 8'h20;
                m_dp[i]   = 1'b0;
            end
            n = 0; m_start = 0; m_fcnt = 0;
            e_seg = 7'h7F; e_dp = 1'b1; e_sel = 4'hF; e_ft = 1'b0;
        end else begin
            digit = (n / SLOT) % ND;
            c     = n % SLOT;
            len   = (msg_len > DEPTH) ? DEPTH : int'(msg_len);
            scr   = scroll_en && (len > ND);
            idx   = scr ? m_start + digit : digit;
            if (scr && idx >= len) idx -= len;
            fend  = (n % FRAME) == FRAME - 1;
            e_sel = 4'hF;
            e_sel[digit] = 1'b0;
            if (c < BLANK || idx >= len) begin
                e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_seg = ref_font(m_char[idx]);
                e_dp  = ~m_dp[idx];
            end
            e_ft = fend;
            if (wr_en && wr_addr < DEPTH) begin
                m_char[wr_addr] = wr_char;
                m_dp[wr_addr]   = wr_dp;
            end
            if (!scr) begin
                m_start = 0; m_fcnt = 0;
            end else if (m_start >= len) begin
                m_start = 0;
            end else if (fend) begin
                if (m_fcnt == SF - 1) begin
                    m_fcnt = 0;
                    m_start = (m_start + 1) % len;
                end else begin
                    m_fcnt++;
                end
            end
            n++;
        end
        #1;
    endtask

    task automatic write_entry(input int a, input logic [7:0] ch,
                               input logic d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_char = ch; wr_dp = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Runs until the DUT shows frame_tick; afterwards the next edge
    // presents slot 0 cycle 0 of a new frame.
    task automatic sync_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < FRAME + 8 && !ok; i++) begin
            tick();
            if (frame_tick === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) tick();
        checks++;
        if (Segments !== 7'h7F) begin
            errors++;
            $display("FAIL reset_seg got=%h want=7f", Segments);
        end
        checks++;
        if (dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_dp got=%b want=1", dp);
        end
        checks++;
        if (SEL !== 4'hF) begin
            errors++;
            $display("FAIL reset_sel got=%b want=1111", SEL);
        end
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick got=%b want=0", frame_tick);
        end
    endtask

    task automatic test_latency();
        rst_n = 1'b1;
        tick();
        checks++;
        if (SEL !== 4'b1110) begin
            errors++;
            $display("FAIL first_sel got=%b want=1110", SEL);
        end
        for (int e = 2; e <= 3 * FRAME + 1; e++) begin
            tick();
            checks++;
            if (frame_tick !== ((e % FRAME) == 0)) begin
                errors++;
                $display("FAIL tick_period edge=%0d got=%b want=%b",
                         e, frame_tick, (e % FRAME) == 0);
            end
        end
    endtask

    task automatic test_static();
        bit ok;
        logic [6:0] exp_seg [4];
        exp_seg = '{7'h79, 7'h08, 7'h3F, 7'h00};
        write_entry(0, 8'h31, 1'b0);
        write_entry(1, 8'h41, 1'b0);
        write_entry(2, 8'h2D, 1'b1);
        write_entry(3, 8'h38, 1'b0);
        msg_len = 4; scroll_en = 1'b0;
        sync_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL static_sync got=timeout want=frame_tick");
        end
        for (int j = 0; j < FRAME; j++) begin
            tick();
            checks++;
            if ({Segments, dp, SEL, frame_tick}
                !== {e_seg, e_dp, e_sel, e_ft}) begin
                errors++;
                $display("FAIL static_model j=%0d got=%h/%b/%b/%b want=%h/%b/%b/%b",
                         j, Segments, dp, SEL, frame_tick,
                         e_seg, e_dp, e_sel, e_ft);
            end
            if (j % SLOT == 0) begin
                checks++;
                if (Segments !== 7'h7F || dp !== 1'b1) begin
                    errors++;
                    $display("FAIL static_blank j=%0d got=%h/%b want=7f/1",
                             j, Segments, dp);
                end
            end
            if (j % SLOT == 4) begin
                checks++;
                if (Segments !== exp_seg[j / SLOT]
                    || dp !== (j / SLOT != 2)) begin
                    errors++;
                    $display("FAIL static_glyph j=%0d got=%h/%b want=%h/%b",
                             j, Segments, dp, exp_seg[j / SLOT],
                             j / SLOT != 2);
                end
            end
        end
    endtask

    task automatic test_short();
        bit ok;
        msg_len = 2; scroll_en = 1'b1;
        repeat (3 * FRAME) tick();
        sync_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL short_sync got=timeout want=frame_tick");
        end
        for (int j = 0; j < FRAME; j++) begin
            tick();
            if (j == 4 || j == 12 || j == 20 || j == 28) begin
                checks++;
                if (Segments !== ((j == 4) ? 7'h79
                                 : (j == 12) ? 7'h08 : 7'h7F)) begin
                    errors++;
                    $display("FAIL short_digit j=%0d got=%h", j, Segments);
                end
            end
        end
    endtask

    task automatic test_scroll();
        bit ok, hit, seen;
        logic [6:0] exp4 [4];
        exp4 = '{7'h19, 7'h12, 7'h40, 7'h79};
        for (int i = 0; i < 6; i++) write_entry(i, 8'h30 + 8'(i), 1'b0);
        msg_len = 6; scroll_en = 1'b1;
        sync_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL scroll_sync got=timeout want=frame_tick");
        end
        seen = 1'b0;
        for (int f = 0; f < 14; f++) begin
            hit = (m_start == 4) && !seen;
            if (hit) seen = 1'b1;
            for (int j = 0; j < FRAME; j++) begin
                tick();
                checks++;
                if ({Segments, dp, SEL, frame_tick}
                    !== {e_seg, e_dp, e_sel, e_ft}) begin
                    errors++;
                    $display("FAIL scroll_model f=%0d j=%0d got=%h/%b/%b/%b want=%h/%b/%b/%b",
                             f, j, Segments, dp, SEL, frame_tick,
                             e_seg, e_dp, e_sel, e_ft);
                end
                if (hit && (j % SLOT == 4)) begin
                    checks++;
                    if (Segments !== exp4[j / SLOT]) begin
                        errors++;
                        $display("FAIL scroll_4501 j=%0d got=%h want=%h",
                                 j, Segments, exp4[j / SLOT]);
                    end
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL scroll_reach4 got=never want=start4");
        end
    endtask

    task automatic test_len_drop();
        bit ok, seen;
        seen = 1'b0;
        for (int f = 0; f < 20 && !seen; f++) begin
            if (m_start == 4) seen = 1'b1;
            else repeat (FRAME) tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL drop_reach4 got=never want=start4");
        end
        repeat (10) tick();
        msg_len = 3;
        for (int j = 0; j < 2 * FRAME; j++) begin
            tick();
            checks++;
            if ({Segments, dp, SEL} !== {e_seg, e_dp, e_sel}) begin
                errors++;
                $display("FAIL drop_model j=%0d got=%h/%b/%b want=%h/%b/%b",
                         j, Segments, dp, SEL, e_seg, e_dp, e_sel);
            end
        end
        msg_len = 6;
        sync_frame(ok);
        tick();
        repeat (4) tick();
        checks++;
        if (Segments !== 7'h40) begin
            errors++;
            $display("FAIL drop_restart got=%h want=40", Segments);
        end
        seen = 1'b0;
        for (int k = 0; k < 20 * FRAME && !seen; k++) begin
            tick();
            if (m_start == 5) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL drop_reach5 got=never want=start5");
        end
        repeat (6) tick();
        msg_len = 5;
        for (int j = 0; j < 8 * FRAME; j++) begin
            tick();
            checks++;
            if ({Segments, dp, SEL} !== {e_seg, e_dp, e_sel}) begin
                errors++;
                $display("FAIL shrink_model j=%0d got=%h/%b/%b want=%h/%b/%b",
                         j, Segments, dp, SEL, e_seg, e_dp, e_sel);
            end
        end
    endtask

    task automatic test_clamp();
        bit ok, hit, seen;
        logic [7:0] extra [6];
        extra = '{8'h36, 8'h37, 8'h38, 8'h39, 8'h41, 8'h62};
        for (int i = 0; i < 6; i++) write_entry(6 + i, extra[i], 1'b0);
        msg_len = 15; scroll_en = 1'b1;
        sync_frame(ok);
        seen = 1'b0;
        for (int f = 0; f < 40 && !seen; f++) begin
            hit = (m_start == 11);
            if (hit) seen = 1'b1;
            for (int j = 0; j < FRAME; j++) begin
                tick();
                checks++;
                if ({Segments, dp, SEL} !== {e_seg, e_dp, e_sel}) begin
                    errors++;
                    $display("FAIL clamp_model f=%0d j=%0d got=%h/%b/%b want=%h/%b/%b",
                             f, j, Segments, dp, SEL, e_seg, e_dp, e_sel);
                end
                if (hit && (j == 4 || j == 12)) begin
                    checks++;
                    if (Segments !== ((j == 4) ? 7'h03 : 7'h40)) begin
                        errors++;
                        $display("FAIL clamp_wrap j=%0d got=%h want=%h",
                                 j, Segments, (j == 4) ? 7'h03 : 7'h40);
                    end
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL clamp_reach11 got=never want=start11");
        end
    endtask

    task automatic test_write_slot();
        bit ok;
        msg_len = 4; scroll_en = 1'b0;
        sync_frame(ok);
        repeat (4) tick();
        wr_en = 1'b1; wr_addr = 4'd0; wr_char = 8'h37; wr_dp = 1'b0;
        tick();
        checks++;
        if (Segments !== 7'h40) begin
            errors++;
            $display("FAIL write_old got=%h want=40", Segments);
        end
        wr_addr = 4'd12; wr_char = 8'h45;
        tick();
        checks++;
        if (Segments !== 7'h78) begin
            errors++;
            $display("FAIL write_new got=%h want=78", Segments);
        end
        wr_en = 1'b0;
        tick();
        checks++;
        if (Segments !== 7'h78) begin
            errors++;
            $display("FAIL write_oob got=%h want=78", Segments);
        end
    endtask

    task automatic test_midreset();
        bit ok;
        sync_frame(ok);
        repeat (2 * SLOT + 3) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({Segments, dp, SEL, frame_tick} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL midreset got=%h/%b/%b/%b want=7f/1/1111/0",
                     Segments, dp, SEL, frame_tick);
        end
        rst_n = 1'b1;
        for (int j = 0; j < FRAME; j++) begin
            tick();
            checks++;
            if ({Segments, dp, SEL} !== {7'h7F, 1'b1, e_sel}) begin
                errors++;
                $display("FAIL midreset_blank j=%0d got=%h/%b/%b want=7f/1/%b",
                         j, Segments, dp, SEL, e_sel);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [8];
        pool = '{8'h30, 8'h35, 8'h41, 8'h64, 8'h2D, 8'h5F, 8'h20, 8'h63};
        for (int k = 0; k < 4000; k++) begin
            wr_en   = ($urandom_range(3) == 0);
            wr_addr = 4'($urandom_range(15));
            wr_char = ($urandom_range(3) == 0) ? 8'($urandom)
                                               : pool[$urandom_range(7)];
            wr_dp   = 1'($urandom);
            if (k % 400 == 0) begin
                msg_len   = 4'($urandom_range(15));
                scroll_en = ($urandom_range(3) != 0);
            end
            tick();
            checks++;
            if ({Segments, dp, SEL, frame_tick}
                !== {e_seg, e_dp, e_sel, e_ft}) begin
                errors++;
                $display("FAIL random_model k=%0d got=%h/%b/%b/%b want=%h/%b/%b/%b",
                         k, Segments, dp, SEL, frame_tick,
                         e_seg, e_dp, e_sel, e_ft);
            end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_static();
        test_short();
        test_scroll();
        test_len_drop();
        test_clamp();
        test_write_slot();
        test_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
